keypad_scanner: RTL and testbench

- Drives the column strobes of a 4x4 matrix keypad and samples its rows.
- Debounces the scanned pattern and presents the pressed key as a 16-bit one-hot code, with valid and new-press strobes.
- It is the producer side of the one-hot key bus; the one-hot-to-digit encoder downstream consumes it.
- Output holds the last accepted key when no key is pressed.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_debounce.sv | 47 ++++
 rtl/keypad_scanner.sv | 113 +++++++++++
 tb/tb_keypad_scanner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared constants and helpers for the 4x4 keypad scanner and its debouncer.
package keypad_pkg;

  localparam int NCOLS = 4;
  localparam int NROWS = 4;
  localparam int NKEYS = 16;

  localparam logic [NCOLS-1:0] COL_RESET = 4'b1110;

  localparam logic [0:0] ST_SCAN = 1'b0;
  localparam logic [0:0] ST_EVAL = 1'b1;

  // True when exactly one key of the scanned pattern is down.
  function automatic logic is_onehot(input logic [NKEYS-1:0] v);
    int cnt;
    cnt = 0;
    for (int i = 0; i < NKEYS; i++) begin
      if (v[i]) cnt++;
    end
    return (cnt == 1);
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-level debouncer: accepts a pattern after DEBOUNCE_SCANS identical full scans
// when it differs from the last accepted pattern.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             eval,
  input  logic [NKEYS-1:0] snapshot,
  output logic             accept,
  output logic [NKEYS-1:0] pattern
);

  localparam int CW = $clog2(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS - 1);

  logic [NKEYS-1:0] prev_scan;
  logic [NKEYS-1:0] accepted;
  logic [CW-1:0]    stable_cnt;
  logic [CW-1:0]    stable_nxt;

  always_comb begin
    stable_nxt = '0;
    if (snapshot == prev_scan) begin
      stable_nxt = (stable_cnt == CNT_MAX) ? CNT_MAX : stable_cnt + 1'b1;
    end
  end

  // Saturation plus the accepted-pattern compare makes each change fire only once.
  assign accept  = eval && (stable_nxt == CNT_MAX) && (snapshot != accepted);
  assign pattern = snapshot;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_scan  <= '0;
      stable_cnt <= '0;
      accepted   <= '0;
    end else if (eval) begin
      prev_scan  <= snapshot;
      stable_cnt <= stable_nxt;
      if (accept) accepted <= snapshot;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with debounced one-hot key output.
// Define KEYPAD_SYNC_EN to add a 2-flop synchronizer on row_in.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NROWS-1:0] row_in,
  output logic [NCOLS-1:0] col_out,
  output logic [NKEYS-1:0] onehot,
  output logic             key_valid,
  output logic             key_pulse
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);

  logic [SW-1:0]    slot_cnt;
  logic [1:0]       col_idx;
  logic [0:0]       state;
  logic [NKEYS-1:0] snapshot;
  logic [NROWS-1:0] rows_s;
  logic             slot_end;
  logic             accept;
  logic [NKEYS-1:0] pattern;

`ifdef KEYPAD_SYNC_EN
  logic [NROWS-1:0] sync1;
  logic [NROWS-1:0] sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= row_in;
      sync2 <= sync1;
    end
  end

  assign rows_s = sync2;
`else
  assign rows_s = row_in;
`endif

  assign slot_end = (slot_cnt == SLOT_LAST);

  // Sample and column advance share the last slot edge, so each column is held SCAN_DIV clocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt <= '0;
      col_idx  <= '0;
      col_out  <= COL_RESET;
      snapshot <= '0;
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) begin
        col_idx <= col_idx + 1'b1;
        col_out <= {col_out[NCOLS-2:0], col_out[NCOLS-1]};
        for (int r = 0; r < NROWS; r++) begin
          snapshot[NCOLS*r + int'(col_idx)] <= ~rows_s[r];
        end
      end
    end
  end

  // EVAL overlaps the first clock of the next column-0 slot; scan timing is untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_SCAN;
    end else begin
      case (state)
        ST_SCAN: if (slot_end && (col_idx == 2'd3)) state <= ST_EVAL;
        default: state <= ST_SCAN;
      endcase
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .eval     (state == ST_EVAL),
    .snapshot (snapshot),
    .accept   (accept),
    .pattern  (pattern)
  );

  // Release and multi-key patterns drop key_valid but keep the last good key visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      onehot    <= '0;
      key_valid <= 1'b0;
      key_pulse <= 1'b0;
    end else begin
      key_pulse <= 1'b0;
      if (accept) begin
        if (is_onehot(pattern)) begin
          onehot    <= pattern;
          key_valid <= 1'b1;
          key_pulse <= 1'b1;
        end else begin
          key_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad matrix model and a pulse scoreboard.
module tb_keypad_scanner;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_pulse;

  logic [15:0] keys;
  int          cyc;
  int          total;
  int          bad;

  logic [15:0] exp_q[$];
  int          exp_cyc_q[$];

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .onehot    (onehot),
    .key_valid (key_valid),
    .key_pulse (key_pulse)
  );

  // clock / reset-relative cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // keypad matrix: a pressed key pulls its row low while its column is strobed
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[4*r + c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  function automatic logic [3:0] col_pat(input int i);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, need %0h (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until_cyc(input int target);
    for (int i = 0; i < 300 && cyc < target; i++) @(negedge clk);
    check("wait_bound", (cyc >= target) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic expect_pulse(input logic [15:0] oh, input int at_cyc);
    exp_q.push_back(oh);
    exp_cyc_q.push_back(at_cyc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    wait_cycles(3);
  endtask

  // scoreboard monitor: every key_pulse must match the head of the expected queue
  task automatic monitor();
    logic [15:0] e_oh;
    int          e_cyc;
    forever begin
      @(negedge clk);
      if (rst_n && key_pulse) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pulse: got onehot=%0h at cyc=%0d, need no pulse", onehot, cyc);
        end else begin
          e_oh  = exp_q.pop_front();
          e_cyc = exp_cyc_q.pop_front();
          check("pulse_onehot", {16'h0, onehot}, {16'h0, e_oh});
          check("pulse_valid", {31'h0, key_valid}, 32'd1);
          if (e_cyc != 0) check("pulse_cycle", cyc, e_cyc);
        end
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    keys  = 16'h0000;
    rst_n = 1'b0;
    fork
      monitor();
    join_none

    // reset state with idle rows
    wait_cycles(3);
    check("rst_col", {28'h0, col_out}, 32'he);
    check("rst_onehot", {16'h0, onehot}, 32'h0);
    check("rst_valid", {31'h0, key_valid}, 32'd0);
    check("rst_pulse", {31'h0, key_pulse}, 32'd0);
    rst_n = 1'b1;

    // column walk, each column held SCAN_DIV clocks
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      check("col_walk", {28'h0, col_out}, {28'h0, col_pat((cyc / 4) % 4)});
    end
    wait_until_cyc(64);
    check("idle_onehot", {16'h0, onehot}, 32'h0);
    check("idle_valid", {31'h0, key_valid}, 32'd0);

    // row1/col2 held from scan 0: pulse right after the third scan's EVAL
    do_reset();
    keys = 16'h0040;
    expect_pulse(16'h0040, 49);
    rst_n = 1'b1;
    wait_until_cyc(100);
    check("press_onehot", {16'h0, onehot}, 32'h0040);
    check("press_valid", {31'h0, key_valid}, 32'd1);
    check("press_q_empty", exp_q.size(), 0);

    // release: valid drops, onehot holds, no pulse
    keys = 16'h0000;
    wait_cycles(80);
    check("release_valid", {31'h0, key_valid}, 32'd0);
    check("release_onehot", {16'h0, onehot}, 32'h0040);

    // bouncing key never stable for 3 scans
    for (int i = 0; i < 10; i++) begin
      keys = (i % 2 == 0) ? 16'h0040 : 16'h0000;
      wait_cycles(12);
    end
    check("bounce_valid", {31'h0, key_valid}, 32'd0);
    check("bounce_onehot", {16'h0, onehot}, 32'h0040);
    check("bounce_q_empty", exp_q.size(), 0);

    // steady re-press gives a second pulse
    keys = 16'h0040;
    expect_pulse(16'h0040, 0);
    wait_cycles(80);
    check("repress_valid", {31'h0, key_valid}, 32'd1);
    check("repress_q_empty", exp_q.size(), 0);

    // two keys together: rejected, onehot holds
    keys = 16'h0801;
    wait_cycles(80);
    check("multi_valid", {31'h0, key_valid}, 32'd0);
    check("multi_onehot", {16'h0, onehot}, 32'h0040);

    // drop row0/col0, row2/col3 remains
    keys = 16'h0800;
    expect_pulse(16'h0800, 0);
    wait_cycles(80);
    check("remain_onehot", {16'h0, onehot}, 32'h0800);
    check("remain_valid", {31'h0, key_valid}, 32'd1);
    check("remain_q_empty", exp_q.size(), 0);

    // new key stable for 2 scans, then reset mid-slot on column 2
    for (int i = 0; i < 20 && (cyc % 16) != 0; i++) @(negedge clk);
    keys = 16'h0001;
    wait_cycles(41);
    check("pre_rst_col", {28'h0, col_out}, 32'hb);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_col", {28'h0, col_out}, 32'he);
    check("mid_rst_onehot", {16'h0, onehot}, 32'h0);
    check("mid_rst_valid", {31'h0, key_valid}, 32'd0);
    check("mid_rst_pulse", {31'h0, key_pulse}, 32'd0);
    wait_cycles(2);
    expect_pulse(16'h0001, 49);
    rst_n = 1'b1;
    wait_until_cyc(100);
    check("post_rst_onehot", {16'h0, onehot}, 32'h0001);
    check("post_rst_valid", {31'h0, key_valid}, 32'd1);
    check("final_q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
